stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arb_pkg.sv | 26 ++
 rtl/stack.sv | 61 ++++++
 rtl/stack_arbiter.sv | 121 ++++++++++++
 tb/tb_stack_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stack_arb_pkg.sv
// Shared constants and types for the two-requester stack arbiter and its LIFO.
package stack_arb_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 8;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // Latched copy of the granted transaction.
  typedef struct packed {
    logic id;
    logic op;
  } txn_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stack.sv
// DEPTH x DATA_W LIFO; pop loads the top entry into a registered output.
module stack
  import stack_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [DATA_W-1:0]             dout_q, dout_d;
  logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
  logic [CW-1:0]                 top;
  logic                          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = dout_q;
  assign top     = cnt_q - CW'(1);

  // Push wins if a caller ever drives both; the arbiter never does.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !push_i && !empty_o;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (do_push) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_d  = top;
      dout_d = mem_q[AW'(top)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[AW'(cnt_q)] <= din_i;
  end

endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter granting two requesters single push/pop transactions on a shared LIFO.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] dout,
  output logic              gnt_id,
  output logic              full,
  output logic              empty
);

  arb_state_e        state_q, state_d;
  txn_t              txn_q, txn_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ptr_q, ptr_d;
  logic              rej_q, rej_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              stk_push, stk_pop;
  logic [DATA_W-1:0] stk_dout;

  stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rstN),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .din_i   (din_q),
    .dout_o  (stk_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    din_d    = din_q;
    ptr_d    = ptr_q;
    rej_d    = rej_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    dout_d   = dout_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          // Pointer only breaks ties; it toggles on every grant.
          txn_d.id = (req0 && req1) ? ptr_q : req1;
          txn_d.op = txn_d.id ? op1 : op0;
          din_d    = txn_d.id ? din1 : din0;
          ptr_d    = ~ptr_q;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (txn_q.op == OP_PUSH) stk_push = !full;
        else                     stk_pop  = !empty;
        rej_d   = !(stk_push || stk_pop);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ack0_d = !txn_q.id;
        ack1_d = txn_q.id;
        err_d  = rej_q;
        if (!rej_q && txn_q.op == OP_POP) dout_d = stk_dout;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstN) begin
    if (rstN) begin
      state_q <= ST_IDLE;
      txn_q   <= '0;
      din_q   <= '0;
      ptr_q   <= 1'b0;
      rej_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      din_q   <= din_d;
      ptr_q   <= ptr_d;
      rej_q   <= rej_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err    = err_q;
  assign dout   = dout_q;
  assign gnt_id = txn_q.id;

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench: stimulus predicts each ack from a queue-based stack model; a monitor checks acks.
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int DW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic          ack0, ack1, err, gnt_id, full, empty;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  stack_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .din0(din0), .din1(din1),
    .ack0(ack0), .ack1(ack1), .err(err), .dout(dout),
    .gnt_id(gnt_id), .full(full), .empty(empty)
  );

  typedef struct {
    bit            id;
    bit            err;
    logic [DW-1:0] dout;
    bit            full;
    bit            empty;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;

  // Reference model: a plain queue as the stack, a tie-break bit, last popped value.
  logic [DW-1:0] mstk[$];
  bit            mptr = 1'b0;
  logic [DW-1:0] mdout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      chk("ack_exclusive", 32'(ack0 && ack1), 32'(0));
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_id",    32'(ack1),  32'(e.id));
        chk("ack_err",   32'(err),   32'(e.err));
        chk("ack_dout",  32'(dout),  32'(e.dout));
        chk("ack_full",  32'(full),  32'(e.full));
        chk("ack_empty", 32'(empty), 32'(e.empty));
        chk("ack_cycle", 32'(cyc),   32'(e.cyc));
      end
    end
  end

  task automatic model_reset();
    mstk.delete();
    mptr  = 1'b0;
    mdout = '0;
  endtask

  task automatic check_reset();
    chk("rst_ack0",   32'(ack0),   32'(0));
    chk("rst_ack1",   32'(ack1),   32'(0));
    chk("rst_err",    32'(err),    32'(0));
    chk("rst_dout",   32'(dout),   32'(0));
    chk("rst_gnt_id", 32'(gnt_id), 32'(0));
    chk("rst_full",   32'(full),   32'(0));
    chk("rst_empty",  32'(empty),  32'(1));
  endtask

  task automatic idle(input int n);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge while the DUT idles; returns at the negedge the ack is visible.
  task automatic do_txn(input bit r0, input bit r1, input bit o0, input bit o1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit fix, input logic [DW-1:0] late);
    exp_t          e;
    bit            w, op;
    logic [DW-1:0] d;
    req0 = r0; req1 = r1; op0 = o0; op1 = o1; din0 = d0; din1 = d1;
    w    = (r0 && r1) ? mptr : r1;
    mptr = !mptr;
    op   = w ? o1 : o0;
    d    = w ? d1 : d0;
    if (op) begin
      e.err = (mstk.size() == DEPTH);
      if (!e.err) mstk.push_back(d);
    end else begin
      e.err = (mstk.size() == 0);
      if (!e.err) mdout = mstk.pop_back();
    end
    e.id    = w;
    e.dout  = mdout;
    e.full  = (mstk.size() == DEPTH);
    e.empty = (mstk.size() == 0);
    @(posedge clk);
    @(negedge clk);
    e.cyc = cyc + 2;
    sb.push_back(e);
    // Inputs after the grant must not influence the transaction.
    req0 = 1'($urandom); req1 = 1'($urandom);
    op0  = 1'($urandom); op1  = 1'($urandom);
    din0 = fix ? late : DW'($urandom);
    din1 = DW'($urandom);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    idle(1);
    rstN = 1'b1;
    model_reset();
    @(posedge clk); @(negedge clk);
    check_reset();
    rstN = 1'b0;
  endtask

  task automatic rst_mid();
    idle(1);
    req0 = 1'b1; op0 = 1'b1; din0 = 4'h5; req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    rstN = 1'b1;
    req0 = 1'b0;
    model_reset();
    @(posedge clk); @(negedge clk);
    check_reset();
    rstN = 1'b0;
  endtask

  initial begin
    rstN = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset();
    rstN = 1'b0;

    do_txn(1, 0, 1, 0, 4'h3, 4'h0, 0, 4'h0);
    do_txn(0, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0);
    do_txn(1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0);

    for (int i = 1; i <= 9; i++) do_txn(1, 0, 1, 0, DW'(i), 4'h0, 0, 4'h0);
    for (int i = 0; i < 8; i++)  do_txn(0, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0);
    do_txn(0, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0);

    do_txn(1, 0, 1, 0, 4'h6, 4'h0, 1, 4'hF);
    do_txn(1, 0, 0, 0, 4'h0, 4'h0, 0, 4'h0);

    do_reset();
    repeat (4) do_txn(1, 1, 1, 1, 4'hA, 4'hB, 0, 4'h0);
    idle(2);

    rst_mid();
    do_txn(1, 0, 1, 0, 4'h7, 4'h0, 0, 4'h0);
    do_txn(0, 1, 0, 0, 4'h0, 4'h0, 0, 4'h0);

    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(3, 1);
      do_txn(1'(r), 1'(r >> 1),
             ($urandom_range(9, 0) < 5), ($urandom_range(9, 0) < 5),
             DW'($urandom), DW'($urandom), 0, 4'h0);
      if ($urandom_range(9, 0) == 0) idle($urandom_range(3, 1));
    end

    idle(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
